// File: rtl/uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl
//   CPU-facing UART transmitter. The CPU stores bytes into a small circular
//   FIFO. A four-state FSM drains the FIFO and sends 8N1 frames on uart_tx,
//   LSB first. Each frame has one start bit, eight data bits and one stop bit,
//   and every bit lasts BAUD_DIV sysclk cycles. When the FIFO still holds data
//   at the end of a stop bit, the next frame follows with no idle gap.
//
// Parameters
//   BAUD_DIV    sysclk cycles per UART bit (2..65535)
//   FIFO_DEPTH  transmit FIFO entries (power of two, 2..256)
//
// Ports
//   sysclk      sole clock, rising edge
//   cpu_reset   asynchronous, active-high reset
//   wr_en       store strobe; one byte accepted per cycle when not full
//   wr_data     byte to queue, sampled with wr_en
//   clr_ovf     clears the sticky overflow flag
//   full        FIFO holds FIFO_DEPTH entries
//   busy        a frame is in flight or bytes are queued
//   fifo_count  number of queued bytes
//   overflow    sticky; set when a write was dropped because the FIFO was full
//   uart_tx     serial output, idles high, driven straight from a flop
// ---------------------------------------------------------------------------
module uart_tx_ctrl #(
  parameter int BAUD_DIV   = 868,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          sysclk,
  input  logic                          cpu_reset,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  input  logic                          clr_ovf,
  output logic                          full,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          uart_tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [AW:0]   DEPTH     = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  logic [CW-1:0]   baud_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  logic            bit_done;
  logic            have_data;
  logic            pop;
  logic            accept;

  assign bit_done  = (baud_cnt == BAUD_LAST);
  assign have_data = (fifo_count != '0);

  // The FSM takes the head byte when it is idle, or at the end of a stop bit.
  // In the stop-bit case the next frame starts on that same edge, so frames
  // run back to back.
  assign pop    = have_data && ((state == IDLE) || ((state == STOP) && bit_done));

  // Acceptance uses the registered full flag, so a write against a full FIFO
  // is dropped even if a pop frees a slot on that same edge.
  assign accept = wr_en && !full;

  assign full = (fifo_count == DEPTH);
  assign busy = (state != IDLE) || have_data;

  // FIFO control and the sticky overflow flag
  always_ff @(posedge sysclk or posedge cpu_reset) begin
    if (cpu_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      if (pop)    rd_ptr <= rd_ptr + AW'(1);

      case ({accept, pop})
        2'b10:   fifo_count <= fifo_count + (AW + 1)'(1);
        2'b01:   fifo_count <= fifo_count - (AW + 1)'(1);
        default: fifo_count <= fifo_count;
      endcase

      // If a drop and a clear land on the same edge, the drop wins.
      if (wr_en && full) overflow <= 1'b1;
      else if (clr_ovf)  overflow <= 1'b0;
    end
  end

  // Data storage needs no reset. The pointers decide which entries are valid.
  always_ff @(posedge sysclk) begin
    if (accept) mem[wr_ptr] <= wr_data;
    if (pop)    shift       <= mem[rd_ptr];
  end

  // uart_tx is written with the line level of the state being entered, so
  // it changes only on state changes or data-bit advances.
  always_ff @(posedge sysclk or posedge cpu_reset) begin
    if (cpu_reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      uart_tx  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          uart_tx  <= 1'b1;
          if (pop) begin
            state   <= START;
            uart_tx <= 1'b0;
          end
        end

        START: begin
          if (bit_done) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
            uart_tx  <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end

        DATA: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state   <= STOP;
              uart_tx <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              uart_tx <= shift[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end

        STOP: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (pop) begin
              state   <= START;
              uart_tx <= 1'b0;
            end else begin
              state   <= IDLE;
              uart_tx <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end

        default: begin
          state    <= IDLE;
          baud_cnt <= '0;
          uart_tx  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_ctrl
//   Bench for uart_tx_ctrl with BAUD_DIV=4 and FIFO_DEPTH=4.
//   A byte-queue/frame-position model predicts every output on each cycle.
//   Directed scenarios cover reset, a single frame, back-to-back frames,
//   overflow, a drop while a pop happens, and reset in the middle of a frame.
//   Literal frame patterns pin the model.
// ---------------------------------------------------------------------------
module tb_uart_tx_ctrl;

  localparam int B = 4;
  localparam int D = 4;

  logic       sysclk    = 1'b0;
  logic       cpu_reset = 1'b0;
  logic       wr_en     = 1'b0;
  logic [7:0] wr_data   = 8'h00;
  logic       clr_ovf   = 1'b0;
  logic       full;
  logic       busy;
  logic [2:0] fifo_count;
  logic       overflow;
  logic       uart_tx;

  int checks = 0;
  int errors = 0;

  uart_tx_ctrl #(.BAUD_DIV(B), .FIFO_DEPTH(D)) dut (
    .sysclk     (sysclk),
    .cpu_reset  (cpu_reset),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .clr_ovf    (clr_ovf),
    .full       (full),
    .busy       (busy),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .uart_tx    (uart_tx)
  );

  always #5 sysclk = ~sysclk;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a byte queue plus the position inside the frame being sent.
  byte unsigned mq[$];
  bit           m_active = 1'b0;
  int           m_pos    = 0;
  logic [7:0]   m_cur    = 8'h00;
  bit           m_ovf    = 1'b0;

  function automatic logic m_tx();
    if (!m_active)      return 1'b1;
    if (m_pos < B)      return 1'b0;
    if (m_pos < 9 * B)  return m_cur[(m_pos - B) / B];
    return 1'b1;
  endfunction

  initial forever begin
    @(posedge sysclk or posedge cpu_reset);
    if (cpu_reset) begin
      mq.delete();
      m_active = 1'b0;
      m_pos    = 0;
      m_ovf    = 1'b0;
    end else begin
      bit acc;
      bit drop;
      bit do_pop;
      acc    = wr_en && (mq.size() < D);
      drop   = wr_en && (mq.size() == D);
      do_pop = 1'b0;
      if (m_active) begin
        if (m_pos == 10 * B - 1) begin
          if (mq.size() > 0) do_pop = 1'b1;
          else               m_active = 1'b0;
        end else begin
          m_pos++;
        end
      end else if (mq.size() > 0) begin
        do_pop = 1'b1;
      end
      if (do_pop) begin
        m_cur    = mq.pop_front();
        m_active = 1'b1;
        m_pos    = 0;
      end
      if (acc) mq.push_back(wr_data);
      if (drop)         m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
    end
  end

  // Compare all outputs against the model on every falling edge.
  initial forever begin
    @(negedge sysclk);
    check("model", {uart_tx, busy, full, overflow, fifo_count},
          {m_tx(), (m_active || (mq.size() != 0)), (mq.size() == D), m_ovf, 3'(mq.size())});
  end

  // Expand a 10-bit frame (start bit first, in MSB) to one bit per cycle.
  function automatic logic [39:0] expand(input logic [9:0] g);
    logic [39:0] e;
    for (int i = 0; i < 40; i++) e[39 - i] = g[9 - i / B];
    return e;
  endfunction

  task automatic write_byte(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    @(posedge sysclk); #1;
    wr_en   = 1'b0;
  endtask

  task automatic capture(input int n, output logic [79:0] v);
    v = '0;
    for (int k = 0; k < n; k++) begin
      @(posedge sysclk); #1;
      v = {v[78:0], uart_tx};
    end
  endtask

  task automatic wait_idle(input int maxc);
    int c;
    c = 0;
    while (busy !== 1'b0 && c < maxc) begin
      @(posedge sysclk); #1;
      c++;
    end
    check("wait_idle", {79'd0, busy}, 80'd0);
  endtask

  initial begin
    logic [79:0] cap;
    logic [79:0] rest;
    logic        first;

    // Reset, with a write attempt that must be ignored while reset is high
    #1 cpu_reset = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'h99;
    repeat (3) @(posedge sysclk);
    #1;
    check("reset_state", {uart_tx, busy, full, overflow, fifo_count}, {1'b1, 1'b0, 1'b0, 1'b0, 3'd0});
    wr_en     = 1'b0;
    cpu_reset = 1'b0;
    @(posedge sysclk); #1;
    check("no_write_in_reset", fifo_count, 0);

    // Single byte 0x55
    write_byte(8'h55);
    capture(40, cap);
    check("frame_55", cap, {40'd0, expand(10'b0101010101)});
    check("busy_before_end", busy, 1);
    @(posedge sysclk); #1;
    check("busy_falls_n41", busy, 0);

    // Back-to-back 0xA5, 0x3C
    wr_en   = 1'b1;
    wr_data = 8'hA5;
    @(posedge sysclk); #1;
    wr_data = 8'h3C;
    @(posedge sysclk); #1;
    wr_en = 1'b0;
    first = uart_tx;
    capture(79, rest);
    cap = {first, rest[78:0]};
    check("frames_a5_3c", cap, {expand(10'b0101001011), expand(10'b0001111001)});
    wait_idle(100);

    // Overflow: six writes while idle
    for (int i = 0; i < 6; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'h11 + 8'(i);
      @(posedge sysclk); #1;
    end
    wr_en = 1'b0;
    check("ovf_full", full, 1);
    check("ovf_count", fifo_count, 4);
    check("ovf_flag", overflow, 1);
    clr_ovf = 1'b1;
    @(posedge sysclk); #1;
    clr_ovf = 1'b0;
    check("ovf_cleared", overflow, 0);

    // Write into a full FIFO on the edge where the stop bit of 0x11 ends
    repeat (34) @(posedge sysclk);
    #1;
    check("full_before_stop_end", full, 1);
    wr_en   = 1'b1;
    wr_data = 8'h77;
    @(posedge sysclk); #1;
    wr_en = 1'b0;
    check("drop_with_pop_ovf", overflow, 1);
    check("drop_with_pop_count", fifo_count, 3);
    check("drop_with_pop_full", full, 0);
    wait_idle(400);

    // Reset during bit 3 of 0x00, with 0x42 queued behind it
    clr_ovf = 1'b1;
    @(posedge sysclk); #1;
    clr_ovf = 1'b0;
    write_byte(8'h00);
    write_byte(8'h42);
    repeat (17) @(posedge sysclk);
    #1;
    check("pre_reset_tx", uart_tx, 0);
    check("pre_reset_count", fifo_count, 1);
    cpu_reset = 1'b1;
    #1;
    check("async_reset_tx", uart_tx, 1);
    check("async_reset_count", fifo_count, 0);
    check("async_reset_busy", busy, 0);
    @(posedge sysclk); #1;
    cpu_reset = 1'b0;
    write_byte(8'hFF);
    capture(40, cap);
    check("frame_ff", cap, {40'd0, expand(10'b0111111111)});
    wait_idle(100);
    check("end_count", fifo_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 Parameter: BAUD_DIV, default 868, sysclk cycles per UART bit (100 MHz / 115200); legal range 2..65535.
REQ-002 Parameter: FIFO_DEPTH, default 16, transmit FIFO entries; power of two, 2..256.
REQ-003 Port: sysclk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: cpu_reset  input  1  asynchronous, active-high reset.
REQ-005 Port: wr_en  input  1  CPU store strobe to the UART data address; one byte per cycle when high.
REQ-006 Port: wr_data  input  8  byte to transmit, sampled when wr_en=1.
REQ-007 Port: clr_ovf  input  1  clears the overflow flag.
REQ-008 Port: full  output  1  FIFO holds FIFO_DEPTH entries.
REQ-009 Port: busy  output  1  high when FSM not IDLE or FIFO non-empty.
REQ-010 Port: fifo_count  output  clog2(FIFO_DEPTH)+1  entries currently queued.
REQ-011 Port: overflow  output  1  sticky; a write was dropped.
REQ-012 Port: uart_tx  output  1  serial line, idle high, registered output.

Function
REQ-013 FIFO: circular buffer; read/write pointers wrap modulo FIFO_DEPTH; fifo_count = writes accepted minus pops.
REQ-014 Write accepted at an edge with wr_en=1 and full=0 (registered value); byte stored at write pointer, pointer increments.
REQ-015 Write with full=1 is dropped, even if a pop occurs at the same edge; overflow set to 1 at that edge.
REQ-016 Accepted write and pop at the same edge: fifo_count unchanged, both pointers advance.
REQ-017 overflow cleared at an edge with clr_ovf=1, unless a drop occurs at that same edge (set wins).
REQ-018 FSM states: IDLE, START, DATA, STOP; one baud counter (0..BAUD_DIV-1) and bit index (0..7).
REQ-019 IDLE: uart_tx=1; at an edge with fifo_count>0, pop head into shift register, baud counter=0, go START.
REQ-020 START: uart_tx=0 for exactly BAUD_DIV cycles; at counter=BAUD_DIV-1, counter=0, bit index=0, go DATA.
REQ-021 DATA: uart_tx=shift[bit index], LSB first, each bit exactly BAUD_DIV cycles; after bit 7 completes, go STOP.
REQ-022 STOP: uart_tx=1 for exactly BAUD_DIV cycles; at completion, if fifo_count>0, pop and go START directly (no idle gap); else go IDLE.
REQ-023 Frame length exactly 10*BAUD_DIV cycles; back-to-back frames contiguous.
REQ-024 Latency: write accepted at edge N into empty FIFO with FSM IDLE -> pop at edge N+1 -> uart_tx=0 from edge N+1.
REQ-025 uart_tx changes only at edges where the FSM changes state or the DATA bit index advances; glitch-free (flop output).
REQ-026 Writes during transmission only queue; they never affect the frame in progress.

Reset
REQ-027 cpu_reset=1 immediately forces: FSM=IDLE, uart_tx=1, pointers=0, fifo_count=0, full=0, busy=0, overflow=0, counters=0.
REQ-028 Reset mid-frame aborts the frame; uart_tx returns high asynchronously; queued bytes are discarded.
REQ-029 While cpu_reset=1, wr_en is ignored; first write accepted at the first edge after deassertion.

Verification (BAUD_DIV=4, FIFO_DEPTH=4)
REQ-030 Single byte: write 0x55 at edge N -> uart_tx low edges N+1..N+4, then bits 1,0,1,0,1,0,1,0 each 4 cycles, high 4 cycles; busy falls at edge N+41.
REQ-031 Back-to-back: write 0xA5, 0x3C on consecutive cycles -> two 40-cycle frames with no idle cycle between stop of first and start of second.
REQ-032 Overflow: 6 consecutive writes while FSM IDLE -> first popped, 4 queued, full=1, 6th dropped, overflow=1; clr_ovf pulse -> overflow=0.
REQ-033 Full with simultaneous pop: FIFO full at STOP completion plus wr_en at that edge -> write dropped, overflow=1, fifo_count=FIFO_DEPTH-1.
REQ-034 Reset mid-DATA: assert cpu_reset during bit 3 of 0x00 -> uart_tx=1 without waiting for an edge, fifo_count=0; write 0xFF after release -> clean frame.
